// File: rtl/m_conv_feeder.sv
// m_conv_feeder: streams NUM_IN RAM pixels gap-free onto conv map_in/start, then zero-pads until conv drops ready.
// Optional M_CONV_FEEDER_CHKSUM_EN adds chksum, a mod-2^16 sum of the streamed pixels of the last map.
module m_conv_feeder #(
  parameter int NUM_IN  = 9216,
  parameter int ADDR_W  = 14,
  parameter int MAX_PAD = 1024
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               go,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic signed [15:0] map_out,
  output logic               start,
  input  logic               conv_ready,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef M_CONV_FEEDER_CHKSUM_EN
  ,
  output logic [15:0]        chksum
`endif
);

  localparam int PAD_W = (MAX_PAD > 1) ? $clog2(MAX_PAD) : 1;
  localparam logic [PAD_W-1:0]  PAD_LAST  = PAD_W'(MAX_PAD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_IN - 1);

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, PAD, FIN} state_t;

  state_t           state;
  logic             rd_q;
  logic [PAD_W-1:0] pad_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_q     <= 1'b0;
      pad_cnt  <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      map_out  <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef M_CONV_FEEDER_CHKSUM_EN
      chksum   <= '0;
`endif
    end else begin
      done <= 1'b0;
      rd_q <= mem_rd;
      // RAM data lands one cycle after the read; forward it straight to the conv port
      if (rd_q) begin
        map_out <= mem_rdata;
        start   <= 1'b1;
`ifdef M_CONV_FEEDER_CHKSUM_EN
        chksum  <= chksum + mem_rdata;
`endif
      end
      case (state)
        IDLE: begin
          if (go) begin
            if (conv_ready) begin
              state    <= STREAM;
              mem_rd   <= 1'b1;
              mem_addr <= '0;
              pad_cnt  <= '0;
              busy     <= 1'b1;
              err      <= 1'b0;
`ifdef M_CONV_FEEDER_CHKSUM_EN
              chksum   <= '0;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (!conv_ready) err <= 1'b1;
          if (mem_addr == LAST_ADDR) begin
            mem_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (!conv_ready) err <= 1'b1;
          state <= PAD;
        end
        PAD: begin
          map_out <= '0;
          start   <= 1'b1;
          // err can only be set here by a premature ready drop, so leave at once
          if (!conv_ready || err) begin
            state <= FIN;
          end else if (pad_cnt == PAD_LAST) begin
            err   <= 1'b1;
            state <= FIN;
          end else begin
            pad_cnt <= pad_cnt + 1'b1;
          end
        end
        FIN: begin
          map_out <= '0;
          start   <= 1'b0;
          busy    <= 1'b0;
          done    <= ~err;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_conv_feeder.sv
// Randomized bench for m_conv_feeder: behavioural model predicts each cycle's outputs from the stream/pad rules.
module tb_m_conv_feeder;
  localparam int NUM_IN  = 16;
  localparam int ADDR_W  = 4;
  localparam int MAX_PAD = 8;
  localparam int NEVER   = 1000;

  logic               clk_in = 1'b0;
  logic               rst_n = 1'b0;
  logic               go = 1'b0;
  logic               conv_ready = 1'b1;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [15:0]        mem_rdata = '0;
  logic signed [15:0] map_out;
  logic               start;
  logic               busy;
  logic               done;
  logic               err;
`ifdef M_CONV_FEEDER_CHKSUM_EN
  logic [15:0]        chksum;
`endif

  logic [15:0] ram [NUM_IN];
  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (mem_rd) mem_rdata <= ram[mem_addr];

  m_conv_feeder #(.NUM_IN(NUM_IN), .ADDR_W(ADDR_W), .MAX_PAD(MAX_PAD)) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .go(go),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .map_out(map_out),
    .start(start),
    .conv_ready(conv_ready),
    .busy(busy),
    .done(done),
    .err(err)
`ifdef M_CONV_FEEDER_CHKSUM_EN
    ,
    .chksum(chksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_err);
    check({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, " start"}, 32'(start), 32'd0);
    check({tag, " map_out"}, 32'($unsigned(map_out)), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'(exp_err));
  endtask

  // drop: first edge index (E0 = go edge) at which conv_ready is sampled 0.
  // abort_k: apply reset right after edge abort_k (-1 = never).
  task automatic run(input string name, input int drop, input bit inject, input int abort_k);
    logic [15:0] pix [NUM_IN];
    logic [15:0] sum;
    int f, err_edge;
    string t;
    sum = '0;
    for (int i = 0; i < NUM_IN; i++) pix[i] = ram[i];
    if (drop <= NUM_IN + 1) begin
      err_edge = drop;
      f = NUM_IN + 2;
    end else if (drop <= NUM_IN + 1 + MAX_PAD) begin
      err_edge = NEVER;
      f = drop;
    end else begin
      err_edge = NUM_IN + 1 + MAX_PAD;
      f = NUM_IN + 1 + MAX_PAD;
    end
    go = 1'b1;
    conv_ready = 1'b1;
    for (int k = 0; k <= f + 2; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      t = $sformatf("%s k=%0d", name, k);
      if (k >= 2 && k <= NUM_IN + 1) sum = sum + pix[k-2];
      check({t, " mem_rd"}, 32'(mem_rd), 32'(k <= NUM_IN - 1));
      if (k <= NUM_IN - 1) check({t, " mem_addr"}, 32'(mem_addr), 32'(k));
      check({t, " map_out"}, 32'($unsigned(map_out)),
            (k >= 2 && k <= NUM_IN + 1) ? 32'(pix[k-2]) : 32'd0);
      check({t, " start"}, 32'(start), 32'(k >= 2 && k <= f));
      check({t, " busy"}, 32'(busy), 32'(k <= f));
      check({t, " done"}, 32'(done), 32'(k == f + 1 && err_edge == NEVER));
      check({t, " err"}, 32'(err), 32'(k >= err_edge));
`ifdef M_CONV_FEEDER_CHKSUM_EN
      check({t, " chksum"}, 32'(chksum), 32'(sum));
`endif
      if (k == abort_k) begin
        rst_n = 1'b0;
        go = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check_idle({name, " abort"}, 1'b0);
        check({name, " abort mem_addr"}, 32'(mem_addr), 32'd0);
`ifdef M_CONV_FEEDER_CHKSUM_EN
        check({name, " abort chksum"}, 32'(chksum), 32'd0);
`endif
        rst_n = 1'b1;
        conv_ready = 1'b1;
        return;
      end
      go = (inject && k + 1 <= f) ? 1'($urandom_range(0, 1)) : 1'b0;
      conv_ready = (k + 1 >= drop) ? 1'b0 : 1'b1;
    end
    go = 1'b0;
    conv_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NUM_IN; i++) ram[i] = 16'(i + 1);

    // reset held with go asserted: reset wins
    rst_n = 1'b0;
    go = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_idle("reset", 1'b0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    run("normal", NUM_IN + 5, 1'b0, -1);
    run("timeout", NEVER, 1'b0, -1);
    repeat (3) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check_idle("sticky", 1'b1);
    end

    go = 1'b1;
    conv_ready = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    go = 1'b0;
    conv_ready = 1'b1;
    check_idle("go not ready", 1'b1);
    @(posedge clk_in);
    @(negedge clk_in);
    check_idle("go not ready hold", 1'b1);
    run("restart", NUM_IN + 4, 1'b0, -1);

    run("abort", NEVER, 1'b0, 9);
    run("after abort", NUM_IN + 2, 1'b0, -1);

    run("premature", 12, 1'b1, -1);
    repeat (2) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check_idle("premature sticky", 1'b1);
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_IN; i++) ram[i] = 16'($urandom);
      run($sformatf("rand%0d", r), int'($urandom_range(1, NUM_IN + MAX_PAD + 4)),
          1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
